dmi_req_arbiter: RTL and testbench

- Core-clock controller that shares the debug-module register bus between two requesters.
- Requester J: the synchronized single-cycle DMI pulses from the JTAG-to-core synchronizer.
- Requester S: a core-side level req/ack debug requester, e.g. an SoC debug mailbox.
- Captures J pulses so none are lost, arbitrates round-robin, sequences one DM access at a time (issue, then wait for ack), and returns read data and a completion to the winner.

---
 rtl/dmi_req_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dmi_req_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_req_arbiter.sv
// Shares the debug-module register bus between JTAG DMI pulses (J) and a core-side req/ack requester (S).
// Optional macro DMI_ARB_TIMEOUT_EN: WAIT timeout forcing an all-ones completion with j_err/s_err.
module dmi_req_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              j_reg_en,
  input  logic              j_reg_wr_en,
  input  logic [ADDR_W-1:0] j_addr,
  input  logic [DATA_W-1:0] j_wdata,
  output logic [DATA_W-1:0] j_rdata,
  output logic              j_done,
  output logic              j_ovf,
  input  logic              j_ovf_clr,
  input  logic              s_req,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_ack,
  output logic [DATA_W-1:0] s_rdata,
  output logic              dm_en,
  output logic              dm_wr_en,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              j_err,
  output logic              s_err,
  output logic [1:0]        dbg_state,
  output logic              dbg_j_pend
);

  // Handshakes: j_reg_en is a one-cycle pulse answered by a one-cycle j_done; s_req is a level held
  // with its payload until the one-cycle s_ack and dropped the cycle after; dm_en is a one-cycle
  // strobe answered by dm_ack no earlier than the next cycle, payload held until then.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              j_pend_q, j_pend_d;
  logic              j_wr_pend_q, j_wr_pend_d;
  logic              j_ovf_q, j_ovf_d;
  logic              rr_q, rr_d;
  logic              gnt_s_q, gnt_s_d;
  logic              dm_wr_q, dm_wr_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0] j_rdata_q, j_rdata_d;
  logic [DATA_W-1:0] s_rdata_q, s_rdata_d;
  logic              j_done_q, j_done_d;
  logic              s_ack_q, s_ack_d;
  logic              j_err_q, j_err_d;
  logic              s_err_q, s_err_d;

  logic              grant_j, grant_s, ovf_set;
  logic              s_req_vld, tmo_expire, done_now;
  logic [DATA_W-1:0] fin_rdata;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_WAIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end

  // The count reaches TIMEOUT at the end of this cycle, so completion follows TIMEOUT WAIT cycles.
  assign tmo_expire = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_expire     = 1'b0;
`endif

  // s_req is still high during the s_ack cycle; it must not re-grant the finished request.
  assign s_req_vld = s_req && !s_ack_q;
  assign done_now  = (state_q == ST_WAIT) && (dm_ack || tmo_expire);
  assign fin_rdata = dm_ack ? dm_rdata : '1;

  always_comb begin
    state_d     = state_q;
    j_pend_d    = j_pend_q;
    j_wr_pend_d = j_wr_pend_q;
    j_ovf_d     = j_ovf_q;
    rr_d        = rr_q;
    gnt_s_d     = gnt_s_q;
    dm_wr_d     = dm_wr_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    j_rdata_d   = j_rdata_q;
    s_rdata_d   = s_rdata_q;
    j_done_d    = 1'b0;
    s_ack_d     = 1'b0;
    j_err_d     = 1'b0;
    s_err_d     = 1'b0;
    grant_j     = 1'b0;
    grant_s     = 1'b0;
    ovf_set     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // rr_q=1 means J was granted last, so S gets priority under contention.
        if (j_pend_q && (!s_req_vld || !rr_q)) grant_j = 1'b1;
        else if (s_req_vld)                     grant_s = 1'b1;
        if (grant_j) begin
          gnt_s_d    = 1'b0;
          dm_wr_d    = j_wr_pend_q;
          dm_addr_d  = j_addr;
          dm_wdata_d = j_wdata;
          state_d    = ST_ISSUE;
        end else if (grant_s) begin
          gnt_s_d    = 1'b1;
          dm_wr_d    = s_wr;
          dm_addr_d  = s_addr;
          dm_wdata_d = s_wdata;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_now) begin
          if (gnt_s_q) begin
            s_rdata_d = fin_rdata;
            s_ack_d   = 1'b1;
            s_err_d   = !dm_ack;
          end else begin
            j_rdata_d = fin_rdata;
            j_done_d  = 1'b1;
            j_err_d   = !dm_ack;
          end
          rr_d    = !gnt_s_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_j) j_pend_d = 1'b0;
    if (j_reg_en) begin
      if (j_pend_q && !grant_j) begin
        ovf_set = 1'b1;
      end else begin
        j_pend_d    = 1'b1;
        j_wr_pend_d = j_reg_wr_en;
      end
    end
    if (j_ovf_clr) j_ovf_d = 1'b0;
    if (ovf_set)   j_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      j_pend_q    <= 1'b0;
      j_wr_pend_q <= 1'b0;
      j_ovf_q     <= 1'b0;
      rr_q        <= 1'b0;
      gnt_s_q     <= 1'b0;
      dm_wr_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      j_rdata_q   <= '0;
      s_rdata_q   <= '0;
      j_done_q    <= 1'b0;
      s_ack_q     <= 1'b0;
      j_err_q     <= 1'b0;
      s_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_pend_q    <= j_pend_d;
      j_wr_pend_q <= j_wr_pend_d;
      j_ovf_q     <= j_ovf_d;
      rr_q        <= rr_d;
      gnt_s_q     <= gnt_s_d;
      dm_wr_q     <= dm_wr_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      j_rdata_q   <= j_rdata_d;
      s_rdata_q   <= s_rdata_d;
      j_done_q    <= j_done_d;
      s_ack_q     <= s_ack_d;
      j_err_q     <= j_err_d;
      s_err_q     <= s_err_d;
    end
  end

  assign dm_en      = (state_q == ST_ISSUE);
  assign dm_wr_en   = dm_wr_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign j_rdata    = j_rdata_q;
  assign s_rdata    = s_rdata_q;
  assign j_done     = j_done_q;
  assign s_ack      = s_ack_q;
  assign j_ovf      = j_ovf_q;
  assign j_err      = j_err_q;
  assign s_err      = s_err_q;
  assign dbg_state  = state_q;
  assign dbg_j_pend = j_pend_q;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Directed bench for dmi_req_arbiter: auto-responding DM model, per-scenario tasks with inline checks.
module tb_dmi_req_arbiter;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk, rst_n;
  logic              j_reg_en, j_reg_wr_en, j_ovf_clr;
  logic [ADDR_W-1:0] j_addr, s_addr;
  logic [DATA_W-1:0] j_wdata, s_wdata;
  logic [DATA_W-1:0] j_rdata, s_rdata;
  logic              j_done, j_ovf, s_req, s_wr, s_ack;
  logic              dm_en, dm_wr_en, dm_ack, j_err, s_err;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic [1:0]        dbg_state;
  logic              dbg_j_pend;

  dmi_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .j_reg_en(j_reg_en), .j_reg_wr_en(j_reg_wr_en), .j_addr(j_addr), .j_wdata(j_wdata),
    .j_rdata(j_rdata), .j_done(j_done), .j_ovf(j_ovf), .j_ovf_clr(j_ovf_clr),
    .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .dm_en(dm_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .j_err(j_err), .s_err(s_err), .dbg_state(dbg_state), .dbg_j_pend(dbg_j_pend)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_cyc, last_j_done_cyc;
  int n_dm_en, n_j_done, n_s_ack, n_j_err;
  int ack_delay = 1;
  int ack_cnt   = 0;
  logic [DATA_W-1:0]        last_j_rdata, last_s_rdata;
  logic                     last_j_err;
  logic [ADDR_W+DATA_W:0]   dm_log[$];
  logic [ADDR_W-1:0]        exp_q[$];

  function automatic logic [DATA_W-1:0] rdata_for(input logic [ADDR_W-1:0] a);
    if (a == 7'h04) return 32'h1234_5678;
    return 32'hC0DE_0000 | {25'd0, a};
  endfunction

  // DM responder and monitor: ack arrives ack_delay cycles after dm_en (0 = never)
  always @(negedge clk) begin
    cyc++;
    dm_ack   = 1'b0;
    dm_rdata = 32'hDEAD_BEEF;
    if (!rst_n) ack_cnt = 0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        dm_ack   = 1'b1;
        dm_rdata = rdata_for(dm_addr);
      end
    end
    if (dm_en) begin
      n_dm_en++;
      dm_log.push_back({dm_wr_en, dm_addr, dm_wdata});
      ack_cnt = ack_delay;
    end
    if (j_done) begin
      n_j_done++;
      last_j_done_cyc = cyc;
      last_j_rdata    = j_rdata;
      last_j_err      = j_err;
    end
    if (s_ack) begin
      n_s_ack++;
      last_s_rdata = s_rdata;
    end
    if (j_err) n_j_err++;
  end

  // driver tasks
  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts;
    n_dm_en = 0; n_j_done = 0; n_s_ack = 0; n_j_err = 0;
    dm_log.delete();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    j_reg_en = 1'b0; j_reg_wr_en = 1'b0; j_ovf_clr = 1'b0; s_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_counts();
  endtask

  task automatic pulse_j(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic clr);
    step();
    j_reg_en = 1'b1; j_reg_wr_en = wr; j_addr = a; j_wdata = d; j_ovf_clr = clr;
    pulse_cyc = cyc;
    step();
    j_reg_en = 1'b0; j_reg_wr_en = 1'b0; j_ovf_clr = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    int n = 0;
    while (dbg_state !== st && n < budget) begin
      step();
      n++;
    end
    total++;
    if (dbg_state !== st) begin
      bad++;
      $display("FAIL %s: state=%0d expected %0d within %0d cycles", name, dbg_state, st, budget);
    end
  endtask

  task automatic wait_j_done(input int target, input int budget, input string name);
    int n = 0;
    while (n_j_done < target && n < budget) begin
      step();
      n++;
    end
    total++;
    if (n_j_done < target) begin
      bad++;
      $display("FAIL %s: j_done count=%0d expected %0d", name, n_j_done, target);
    end
  endtask

  // scenarios
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) step();
    total++;
    if ({dm_en, dm_wr_en, j_done, s_ack, j_ovf, j_err, s_err, dbg_state, dbg_j_pend} !== 10'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b expected 0", {dm_en, dm_wr_en, j_done, s_ack, j_ovf, j_err, s_err, dbg_state, dbg_j_pend});
    end
    total++;
    if ({j_rdata, s_rdata, dm_addr, dm_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_data: j_rdata=%h s_rdata=%h dm_addr=%h dm_wdata=%h expected 0", j_rdata, s_rdata, dm_addr, dm_wdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_j_read;
    logic [ADDR_W+DATA_W:0] e;
    do_reset();
    ack_delay = 1;
    pulse_j(1'b0, 7'h04, 32'h0, 1'b0);
    wait_j_done(1, 20, "j_read_done");
    repeat (3) step();
    total++;
    if (last_j_done_cyc - pulse_cyc !== 4) begin
      bad++;
      $display("FAIL j_read_latency: got %0d cycles expected 4", last_j_done_cyc - pulse_cyc);
    end
    total++;
    if (last_j_rdata !== 32'h1234_5678 || j_rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL j_read_rdata: got %h/%h expected 12345678", last_j_rdata, j_rdata);
    end
    e = (dm_log.size() > 0) ? dm_log[0] : '1;
    total++;
    if (n_dm_en !== 1 || e[ADDR_W+DATA_W] !== 1'b0 || e[DATA_W +: ADDR_W] !== 7'h04) begin
      bad++;
      $display("FAIL j_read_dm: dm_en=%0d wr=%b addr=%h expected 1/0/04", n_dm_en, e[ADDR_W+DATA_W], e[DATA_W +: ADDR_W]);
    end
    total++;
    if (n_j_done !== 1 || j_ovf !== 1'b0) begin
      bad++;
      $display("FAIL j_read_once: j_done=%0d j_ovf=%b expected 1/0", n_j_done, j_ovf);
    end
  endtask

  task automatic test_j_then_s;
    int n = 0;
    do_reset();
    ack_delay = 1;
    // J pulse captured first; S raises its level while J is pending so both contend in IDLE
    pulse_j(1'b1, 7'h10, 32'hA5A5_A5A5, 1'b0);
    s_req = 1'b1; s_wr = 1'b0; s_addr = 7'h11; s_wdata = 32'h0;
    while (n_s_ack == 0 && n < 30) begin
      step();
      n++;
    end
    step();
    s_req = 1'b0;
    repeat (6) step();
    total++;
    if (n_dm_en !== 2 || n_s_ack !== 1 || n_j_done !== 1) begin
      bad++;
      $display("FAIL js_counts: dm_en=%0d s_ack=%0d j_done=%0d expected 2/1/1", n_dm_en, n_s_ack, n_j_done);
    end
    total++;
    if (dm_log.size() < 2 || dm_log[0] !== {1'b1, 7'h10, 32'hA5A5_A5A5} || dm_log[1] !== {1'b0, 7'h11, 32'h0}) begin
      bad++;
      $display("FAIL js_order: first=%h second=%h expected J write then S read", dm_log.size() > 0 ? dm_log[0] : '0, dm_log.size() > 1 ? dm_log[1] : '0);
    end
    total++;
    if (last_j_rdata !== 32'hC0DE_0010 || last_s_rdata !== 32'hC0DE_0011) begin
      bad++;
      $display("FAIL js_rdata: j=%h s=%h expected c0de0010/c0de0011", last_j_rdata, last_s_rdata);
    end
  endtask

  task automatic test_overflow;
    int n = 0;
    logic [ADDR_W+DATA_W:0] e;
    do_reset();
    ack_delay = 6;
    pulse_j(1'b0, 7'h20, 32'h0, 1'b0);
    wait_state(2'd2, 10, "ovf_wait_a");
    pulse_j(1'b0, 7'h20, 32'h0, 1'b0);
    total++;
    if (dbg_j_pend !== 1'b1 || j_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_second: j_pend=%b j_ovf=%b expected 1/0", dbg_j_pend, j_ovf);
    end
    pulse_j(1'b1, 7'h20, 32'h0, 1'b1);
    total++;
    if (j_ovf !== 1'b1 || dbg_j_pend !== 1'b1) begin
      bad++;
      $display("FAIL ovf_third: j_ovf=%b j_pend=%b expected 1/1", j_ovf, dbg_j_pend);
    end
    wait_j_done(2, 40, "ovf_done");
    repeat (10) step();
    e = (dm_log.size() > 1) ? dm_log[1] : '1;
    total++;
    if (n_dm_en !== 2 || e[ADDR_W+DATA_W] !== 1'b0) begin
      bad++;
      $display("FAIL ovf_accesses: dm_en=%0d second_wr=%b expected 2/0", n_dm_en, e[ADDR_W+DATA_W]);
    end
    j_ovf_clr = 1'b1;
    step();
    j_ovf_clr = 1'b0;
    total++;
    if (j_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: j_ovf=%b expected 0", j_ovf);
    end
    // pulse landing exactly on a J grant is a fresh request, not an overflow
    do_reset();
    ack_delay = 3;
    pulse_j(1'b0, 7'h21, 32'h0, 1'b0);
    wait_state(2'd2, 10, "coin_wait_a");
    pulse_j(1'b0, 7'h21, 32'h0, 1'b0);
    while (j_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    j_reg_en = 1'b1;
    step();
    j_reg_en = 1'b0;
    total++;
    if (dbg_j_pend !== 1'b1 || j_ovf !== 1'b0 || dbg_state !== 2'd1) begin
      bad++;
      $display("FAIL coin_grant: j_pend=%b j_ovf=%b state=%0d expected 1/0/1", dbg_j_pend, j_ovf, dbg_state);
    end
    wait_j_done(3, 40, "coin_done");
    total++;
    if (n_dm_en !== 3) begin
      bad++;
      $display("FAIL coin_accesses: dm_en=%0d expected 3", n_dm_en);
    end
  endtask

  task automatic test_fairness;
    bit s_drop = 0;
    bit s_raise = 0;
    logic [ADDR_W-1:0] got;
    do_reset();
    ack_delay = 1;
    j_addr = 7'h31; j_wdata = '0; j_reg_wr_en = 1'b0;
    s_addr = 7'h30; s_wr = 1'b0; s_wdata = '0;
    s_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      j_reg_en = (dbg_j_pend == 1'b0) && !j_reg_en;
      if (s_raise) begin s_req = 1'b1; s_raise = 0; end
      if (s_drop) begin s_req = 1'b0; s_drop = 0; s_raise = 1; end
      if (s_ack) s_drop = 1;
    end
    j_reg_en = 1'b0;
    s_req = 1'b0;
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 2 == 0) ? 7'h30 : 7'h31);
    total++;
    if (dm_log.size() < 10) begin
      bad++;
      $display("FAIL fair_count: accesses=%0d expected at least 10", dm_log.size());
    end
    for (int i = 0; i < 10 && i < dm_log.size(); i++) begin
      got = dm_log[i][DATA_W +: ADDR_W];
      total++;
      if (got !== exp_q[0]) begin
        bad++;
        $display("FAIL fair_order[%0d]: addr=%h expected %h", i, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    do_reset();
    ack_delay = 0;
    pulse_j(1'b0, 7'h05, 32'h0, 1'b0);
    wait_state(2'd2, 10, "rmid_wait");
    clear_counts();
    rst_n = 1'b0;
    #1;
    total++;
    if (dbg_state !== 2'd0 || dm_en !== 1'b0 || j_done !== 1'b0 || s_ack !== 1'b0) begin
      bad++;
      $display("FAIL rmid_during: state=%0d dm_en=%b j_done=%b s_ack=%b expected 0", dbg_state, dm_en, j_done, s_ack);
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    total++;
    if (dbg_state !== 2'd0 || dbg_j_pend !== 1'b0 || n_j_done !== 0 || n_dm_en !== 0 || n_s_ack !== 0) begin
      bad++;
      $display("FAIL rmid_after: state=%0d j_pend=%b j_done=%0d dm_en=%0d s_ack=%0d expected 0", dbg_state, dbg_j_pend, n_j_done, n_dm_en, n_s_ack);
    end
    ack_delay = 1;
    pulse_j(1'b0, 7'h04, 32'h0, 1'b0);
    wait_j_done(1, 20, "rmid_new_done");
    total++;
    if (last_j_rdata !== 32'h1234_5678 || n_dm_en !== 1) begin
      bad++;
      $display("FAIL rmid_new: rdata=%h dm_en=%0d expected 12345678/1", last_j_rdata, n_dm_en);
    end
  endtask

  task automatic test_timeout;
`ifdef DMI_ARB_TIMEOUT_EN
    int n = 0;
    int wait_cnt = 0;
    do_reset();
    ack_delay = 0;
    pulse_j(1'b0, 7'h06, 32'h0, 1'b0);
    while (j_done !== 1'b1 && n < 40) begin
      if (dbg_state == 2'd2) wait_cnt++;
      step();
      n++;
    end
    total++;
    if (j_done !== 1'b1 || j_err !== 1'b1 || j_rdata !== 32'hFFFF_FFFF || wait_cnt !== TIMEOUT) begin
      bad++;
      $display("FAIL tmo_expire: done=%b err=%b rdata=%h waits=%0d expected 1/1/ffffffff/%0d", j_done, j_err, j_rdata, wait_cnt, TIMEOUT);
    end
    do_reset();
    ack_delay = TIMEOUT;
    pulse_j(1'b0, 7'h07, 32'h0, 1'b0);
    wait_j_done(1, 40, "tmo_race_done");
    total++;
    if (last_j_err !== 1'b0 || last_j_rdata !== 32'hC0DE_0007) begin
      bad++;
      $display("FAIL tmo_race: err=%b rdata=%h expected 0/c0de0007", last_j_err, last_j_rdata);
    end
`else
    do_reset();
    ack_delay = 0;
    pulse_j(1'b0, 7'h06, 32'h0, 1'b0);
    repeat (300) step();
    total++;
    if (dbg_state !== 2'd2 || n_j_err !== 0 || n_j_done !== 0) begin
      bad++;
      $display("FAIL no_tmo: state=%0d j_err=%0d j_done=%0d expected 2/0/0", dbg_state, n_j_err, n_j_done);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    j_reg_en = 1'b0; j_reg_wr_en = 1'b0; j_addr = '0; j_wdata = '0; j_ovf_clr = 1'b0;
    s_req = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
    dm_ack = 1'b0; dm_rdata = '0;
    clear_counts();
    test_reset();
    test_j_read();
    test_j_then_s();
    test_overflow();
    test_fairness();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
